// File: rtl/card_map_writer.sv
// card_map_writer
// Owns the board state read by the display path: an ROWS x COLS card map
// (6-bit code per slot, EMPTY = no card), per-slot selection bits and an
// occupied-slot count. Game logic updates it through a valid/ready command
// stream. Every map write, including the bulk CLEAR_ALL sweep, goes through
// one write port at one slot per cycle.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready : command handshake; ready is high exactly in IDLE
//   cmd_op          : 0 NOP, 1 PUT, 2 TAKE, 3 SEL_TOGGLE, 4 SEL_CLEAR,
//                     5 CLEAR_ALL, 6/7 reserved (rejected)
//   cmd_pos         : slot index row*COLS + col
//   cmd_card        : card code for PUT
//   map             : slot p at bits [p*6 +: 6]
//   sel_card        : slot p at bit p
//   card_cnt        : number of non-EMPTY slots
//   cmd_err         : one-cycle pulse, accepted command rejected
//   sweep_done      : one-cycle pulse, CLEAR_ALL finished
module card_map_writer #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 18,
  parameter logic [5:0]  EMPTY = 6'd63,
  parameter int unsigned NCARD = 54
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [7:0]               cmd_pos,
  input  logic [5:0]               cmd_card,
  output logic [ROWS*COLS*6-1:0]   map,
  output logic [ROWS*COLS-1:0]     sel_card,
  output logic [7:0]               card_cnt,
  output logic                     cmd_err,
  output logic                     sweep_done
);

  localparam int unsigned NSLOT    = ROWS * COLS;
  localparam logic [8:0]  NSLOT_W  = 9'(NSLOT);
  localparam logic [6:0]  NCARD_W  = 7'(NCARD);
  localparam logic [7:0]  LAST_IDX = 8'(NSLOT - 1);

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_PUT        = 3'd1;
  localparam logic [2:0] OP_TAKE       = 3'd2;
  localparam logic [2:0] OP_SEL_TOGGLE = 3'd3;
  localparam logic [2:0] OP_SEL_CLEAR  = 3'd4;
  localparam logic [2:0] OP_CLEAR_ALL  = 3'd5;

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             idx_q, idx_d;
  logic [NSLOT*6-1:0]     map_q, map_d;
  logic [NSLOT-1:0]       sel_q, sel_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;

  logic                   pos_ok;
  logic                   card_ok;
  logic [7:0]             rd_pos;
  logic [9:0]             rd_base;
  logic [5:0]             rd_slot;
  logic                   occupied;
  logic                   wr_en;
  logic [5:0]             wr_data;

  // One shared slot address: the sweep index while sweeping, otherwise the
  // command position (forced to 0 when out of range so the read stays in
  // bounds; such commands are rejected anyway). The write port uses the
  // same address, since every write targets the slot just inspected.
  always_comb begin
    pos_ok   = ({1'b0, cmd_pos} < NSLOT_W);
    card_ok  = ({1'b0, cmd_card} < NCARD_W);
    rd_pos   = (state_q == S_SWEEP) ? idx_q : (pos_ok ? cmd_pos : '0);
    rd_base  = 10'(rd_pos) * 10'd6;
    rd_slot  = map_q[rd_base +: 6];
    occupied = (rd_slot != EMPTY);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_data = EMPTY;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP: ;
            OP_PUT: begin
              if (pos_ok && card_ok) begin
                wr_en   = 1'b1;
                wr_data = cmd_card;
                if (!occupied) cnt_d = cnt_q + 8'd1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_TAKE: begin
              if (pos_ok && occupied) begin
                wr_en         = 1'b1;
                sel_d[rd_pos] = 1'b0;
                cnt_d         = cnt_q - 8'd1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_SEL_TOGGLE: begin
              if (pos_ok && occupied) sel_d[rd_pos] = ~sel_q[rd_pos];
              else                    err_d = 1'b1;
            end
            OP_SEL_CLEAR: sel_d = '0;
            OP_CLEAR_ALL: begin
              state_d = S_SWEEP;
              idx_d   = '0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_SWEEP: begin
        wr_en         = 1'b1;
        sel_d[rd_pos] = 1'b0;
        if (occupied) cnt_d = cnt_q - 8'd1;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    map_d = map_q;
    if (wr_en) map_d[rd_base +: 6] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      map_q   <= {NSLOT{EMPTY}};
      sel_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      map_q   <= map_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign map        = map_q;
  assign sel_card   = sel_q;
  assign card_cnt   = cnt_q;
  assign cmd_err    = err_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_card_map_writer.sv
// Bench for card_map_writer: a slot-array reference model updated on each
// rising edge, compared against every DUT output on each falling edge, plus
// directed scenarios with hand-computed expectations and a random phase.
module tb_card_map_writer;

  localparam int         N     = 144;
  localparam logic [5:0] EMPTY = 6'd63;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [7:0]   cmd_pos = '0;
  logic [5:0]   cmd_card = '0;
  logic [N*6-1:0] map;
  logic [N-1:0] sel_card;
  logic [7:0]   card_cnt;
  logic         cmd_err;
  logic         sweep_done;

  card_map_writer #(
    .ROWS(8), .COLS(18), .EMPTY(6'd63), .NCARD(54)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_pos(cmd_pos), .cmd_card(cmd_card),
    .map(map), .sel_card(sel_card), .card_cnt(card_cnt),
    .cmd_err(cmd_err), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot array, select array, sweep progress.
  logic [5:0] m_map [N];
  bit         m_sel [N];
  bit         m_sweep, m_err, m_done;
  int         m_k, mp;
  bit         minr, mocc;

  function automatic int m_count();
    int c = 0;
    foreach (m_map[i]) if (m_map[i] != EMPTY) c++;
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_map[i]) begin m_map[i] = EMPTY; m_sel[i] = 0; end
      m_sweep = 0; m_k = 0; m_err = 0; m_done = 0;
    end else begin
      m_err = 0; m_done = 0;
      if (m_sweep) begin
        m_map[m_k] = EMPTY;
        m_sel[m_k] = 0;
        if (m_k == N - 1) begin m_sweep = 0; m_done = 1; end
        else m_k++;
      end else if (cmd_valid) begin
        mp   = int'(cmd_pos);
        minr = (mp < N);
        mocc = minr && (m_map[mp] != EMPTY);
        case (cmd_op)
          3'd1: if (minr && cmd_card < 6'd54) m_map[mp] = cmd_card; else m_err = 1;
          3'd2: if (mocc) begin m_map[mp] = EMPTY; m_sel[mp] = 0; end else m_err = 1;
          3'd3: if (mocc) m_sel[mp] = !m_sel[mp]; else m_err = 1;
          3'd4: foreach (m_sel[i]) m_sel[i] = 0;
          3'd5: begin m_sweep = 1; m_k = 0; end
          3'd6, 3'd7: m_err = 1;
          default: ;
        endcase
      end
    end
  end

  int cbad, cbs;
  always @(negedge clk) begin
    if (!rst) begin
      cbad = 0;
      for (int i = 0; i < N; i++) if (map[i*6 +: 6] !== m_map[i]) begin cbad = i; break; end
      chk("map_slot", 64'(map[cbad*6 +: 6]), 64'(m_map[cbad]));
      cbs = 0;
      for (int i = 0; i < N; i++) if (sel_card[i] !== m_sel[i]) begin cbs = i; break; end
      chk("sel_bit", 64'(sel_card[cbs]), 64'(m_sel[cbs]));
      chk("card_cnt", 64'(card_cnt), 64'(m_count()));
      chk("cmd_err", 64'(cmd_err), 64'(m_err));
      chk("sweep_done", 64'(sweep_done), 64'(m_done));
      chk("cmd_ready", 64'(cmd_ready), 64'(!m_sweep));
    end
  end

  // Call at a falling edge; holds the command until accepted, returns at the
  // falling edge after the accepting rising edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] pos, input logic [5:0] card);
    int w = 0;
    cmd_op = op; cmd_pos = pos; cmd_card = card; cmd_valid = 1'b1;
    while (!cmd_ready && w < 400) begin @(negedge clk); w++; end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_wait waited=%0d limit=400", w);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  int low, dn, first_ready, nz, u;
  logic [2:0] rop;
  logic [7:0] rpos;
  logic [5:0] rcard;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 1);
    chk("rst_cnt", 64'(card_cnt), 0);
    chk("rst_slot0", 64'(map[5:0]), 63);

    // corner slots
    issue(3'd1, 8'd0, 6'd5);
    issue(3'd1, 8'd143, 6'd53);
    chk("t1_slot0", 64'(map[5:0]), 5);
    chk("t1_slot143", 64'(map[863:858]), 53);
    chk("t1_cnt", 64'(card_cnt), 2);
    chk("t1_err", 64'(cmd_err), 0);

    // overwrite and range errors
    do_reset();
    issue(3'd1, 8'd20, 6'd7);
    issue(3'd1, 8'd20, 6'd9);
    chk("t2_slot20", 64'(map[125:120]), 9);
    chk("t2_cnt", 64'(card_cnt), 1);
    issue(3'd1, 8'd144, 6'd1);
    chk("t2_err_pos", 64'(cmd_err), 1);
    chk("t2_cnt_pos", 64'(card_cnt), 1);
    issue(3'd1, 8'd21, 6'd54);
    chk("t2_err_card", 64'(cmd_err), 1);
    chk("t2_slot21", 64'(map[131:126]), 63);
    @(negedge clk);
    chk("t2_err_pulse", 64'(cmd_err), 0);

    // select / take
    issue(3'd1, 8'd3, 6'd12);
    issue(3'd3, 8'd3, 6'd0);
    chk("t3_sel3", 64'(sel_card[3]), 1);
    issue(3'd2, 8'd3, 6'd0);
    chk("t3_slot3", 64'(map[23:18]), 63);
    chk("t3_sel3_clr", 64'(sel_card[3]), 0);
    chk("t3_cnt", 64'(card_cnt), 1);
    issue(3'd3, 8'd4, 6'd0);
    chk("t3_err_empty", 64'(cmd_err), 1);
    chk("t3_sel4", 64'(sel_card[4]), 0);

    // SEL_CLEAR
    do_reset();
    for (int i = 0; i < 10; i++) issue(3'd1, 8'(10 + i), 6'(i));
    for (int i = 0; i < 4; i++) issue(3'd3, 8'(10 + i), 6'd0);
    chk("t4_sel_cnt", 64'($countones(sel_card)), 4);
    issue(3'd4, 8'd0, 6'd0);
    chk("t4_sel_zero", 64'($countones(sel_card)), 0);
    chk("t4_cnt", 64'(card_cnt), 10);
    chk("t4_slot15", 64'(map[95:90]), 5);

    // CLEAR_ALL with a held PUT behind it
    do_reset();
    issue(3'd1, 8'd0, 6'd1);
    issue(3'd1, 8'd70, 6'd2);
    issue(3'd1, 8'd143, 6'd3);
    cmd_op = 3'd5; cmd_pos = 8'd0; cmd_card = 6'd0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 3'd1; cmd_pos = 8'd5; cmd_card = 6'd1;
    low = 0; dn = 0; first_ready = -1;
    for (int k = 0; k <= 146; k++) begin
      if (!cmd_ready) low++;
      else if (first_ready < 0) first_ready = k;
      if (sweep_done) dn++;
      if (k == 0)   chk("t5_cnt_T0", 64'(card_cnt), 3);
      if (k == 1)   chk("t5_cnt_T1", 64'(card_cnt), 2);
      if (k == 70)  chk("t5_cnt_T70", 64'(card_cnt), 2);
      if (k == 71)  chk("t5_cnt_T71", 64'(card_cnt), 1);
      if (k == 143) chk("t5_cnt_T143", 64'(card_cnt), 1);
      if (k == 144) begin
        chk("t5_cnt_T144", 64'(card_cnt), 0);
        chk("t5_done_T144", 64'(sweep_done), 1);
      end
      if (k == 145) begin
        chk("t5_put_slot5", 64'(map[35:30]), 1);
        chk("t5_put_cnt", 64'(card_cnt), 1);
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("t5_ready_low", 64'(low), 144);
    chk("t5_done_count", 64'(dn), 1);
    chk("t5_first_ready", 64'(first_ready), 144);

    // reset mid-sweep
    issue(3'd1, 8'd100, 6'd4);
    issue(3'd5, 8'd0, 6'd0);
    repeat (60) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    nz = 0;
    for (int i = 0; i < N; i++) if (map[i*6 +: 6] !== EMPTY) nz++;
    chk("t6_map_empty", 64'(nz), 0);
    chk("t6_sel", 64'($countones(sel_card)), 0);
    chk("t6_cnt", 64'(card_cnt), 0);
    chk("t6_err", 64'(cmd_err), 0);
    chk("t6_done", 64'(sweep_done), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("t6_ready", 64'(cmd_ready), 1);
    dn = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sweep_done) dn++;
    end
    chk("t6_no_done", 64'(dn), 0);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      u = int'($urandom_range(0, 99));
      if (u < 40)      rop = 3'd1;
      else if (u < 60) rop = 3'd2;
      else if (u < 78) rop = 3'd3;
      else if (u < 83) rop = 3'd4;
      else if (u < 85) rop = 3'd5;
      else if (u < 90) rop = 3'd0;
      else             rop = 3'(6 + $urandom_range(0, 1));
      rpos  = ($urandom_range(0, 99) < 88) ? 8'($urandom_range(0, 143)) : 8'($urandom_range(144, 255));
      rcard = ($urandom_range(0, 9) != 0) ? 6'($urandom_range(0, 53)) : 6'($urandom_range(54, 63));
      issue(rop, rpos, rcard);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_map_writer.md
# card_map_writer

Owns the board state consumed by the display path. Holds the 8×18 card map (6-bit card code per slot) and the per-slot selection bits, and updates them from a valid/ready command stream issued by game logic. Drives the flattened `map` and `sel_card` buses read by the display top, plus an occupied-slot count. All map writes, including bulk clear, go through a single write port at one position per cycle.

## Interface
Parameters:
- `ROWS`, 8, board rows
- `COLS`, 18, board columns
- `EMPTY`, 6'd63, card code meaning "no card"
- `NCARD`, 54, valid card codes are 0..NCARD-1

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cmd_valid`  in  1  command present; fields held stable until accepted
- `cmd_ready`  out  1  block can accept; high exactly when state is IDLE
- `cmd_op`  in  3  opcode (see Operation)
- `cmd_pos`  in  8  slot index = row*18 + col, legal 0..143
- `cmd_card`  in  6  card code for PUT
- `map`  out  8*18*6  slot p at bits [p*6 +: 6]
- `sel_card`  out  8*18  slot p at bit p
- `card_cnt`  out  8  number of slots holding a non-EMPTY code, 0..144
- `cmd_err`  out  1  one-cycle pulse: accepted command rejected
- `sweep_done`  out  1  one-cycle pulse: CLEAR_ALL finished

## Operation
- Accept = `cmd_valid & cmd_ready` at a rising edge. One command per edge max.
- Opcodes:
  - 0 NOP: no state change.
  - 1 PUT: `map[pos]=card`; `card_cnt+1` if slot was EMPTY, unchanged if overwriting. Error if `pos>143` or `card>=54`.
  - 2 TAKE: `map[pos]=EMPTY`, `sel[pos]=0`, `card_cnt-1`. Error if `pos>143` or slot EMPTY.
  - 3 SEL_TOGGLE: `sel[pos]^=1`. Error if `pos>143` or slot EMPTY.
  - 4 SEL_CLEAR: all `sel_card` bits to 0 in one edge; map untouched.
  - 5 CLEAR_ALL: enter SWEEP.
  - 6, 7 reserved: error.
- Errored command: no state change at all, `cmd_err` pulses.
- FSM: IDLE, SWEEP.
  - IDLE → SWEEP on accepted CLEAR_ALL; `idx` loaded 0.
  - SWEEP: each edge writes `map[idx]=EMPTY`, `sel[idx]=0`, decrements `card_cnt` if slot was occupied, `idx++`. On the edge writing idx 143 → IDLE.
- Invariant: `card_cnt` always equals the number of non-EMPTY slots; `sel_card[p]=1` only when `map[p]!=EMPTY`.
- `card_cnt` is 8 bits; never wraps (invariant bounds it to 0..144).

## Timing
- Reset (async, immediate, any state including mid-sweep): all `map` slots = EMPTY, `sel_card=0`, `card_cnt=0`, `cmd_err=0`, `sweep_done=0`, state IDLE, `idx=0`; `cmd_ready=1` as soon as reset deasserts.
- All outputs are registered except `cmd_ready` (decoded from state).
- Single-edge ops: effect visible on `map`/`sel_card`/`card_cnt` the cycle after the accepting edge; `cmd_err` high during that same cycle only.
- CLEAR_ALL accepted at edge T0: `cmd_ready` low from T0 until edge T144. Slots 0..143 cleared at edges T1..T144. `sweep_done` and `cmd_ready` high in the cycle after T144; `sweep_done` for one cycle only.
- Back-to-back commands from IDLE: one per cycle, no bubble.
- `cmd_valid` while `cmd_ready` low: ignored, not queued; the issuer keeps it asserted until acceptance.

## Test plan
- Reset, then PUT pos=0 card=5, PUT pos=143 card=53 → `map[5:0]=5`, `map[863:858]=53`, `card_cnt=2`, no `cmd_err`.
- PUT pos=20 card=7 then PUT pos=20 card=9 → slot 20 = 9, `card_cnt=1`; PUT pos=144 and PUT card=54 → `cmd_err` pulse each, map/count unchanged.
- PUT pos=3, SEL_TOGGLE pos=3 → `sel_card[3]=1`; TAKE pos=3 → slot EMPTY, `sel_card[3]=0`, `card_cnt` back; SEL_TOGGLE on an EMPTY slot → `cmd_err`, sel unchanged.
- Fill 10 slots, select 4, SEL_CLEAR → `sel_card=0`, map and `card_cnt=10` unchanged.
- Fill slots 0, 70, 143; CLEAR_ALL with `cmd_valid` held on a following PUT → `cmd_ready` low exactly 144 cycles, `card_cnt` steps 3→2 (after T1)→1 (after T71)→0 (after T144), `sweep_done` single pulse, the held PUT accepted on the first cycle `cmd_ready` returns.
- Assert `rst` mid-sweep (idx≈60) → all outputs immediately at reset values, `cmd_ready=1` after release, no `sweep_done`.
